dshot_scheduler: RTL and testbench

- Frame-rate scheduler and arming controller for four DShot motor channels.
- Drives the `command`/`send` inputs of four `motor_control` instances at a fixed update rate.
- Owns the arming sequence: disarmed-stop, an armed-zero hold, then throttle.
- Injects repeated DShot special commands while disarmed.
- Sits between the flight-control mixer outputs and the per-motor DShot transmitters.

---
 rtl/dshot_pkg.sv | 32 +++
 rtl/dshot_frame_timer.sv | 26 ++
 rtl/dshot_scheduler.sv | 160 ++++++++++++++++
 tb/tb_dshot_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
// Shared types, DShot command constants and command-mapping helpers for the
// motor frame scheduler.
package dshot_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMING,
    ST_ARMED,
    ST_SPECIAL
  } state_t;

  localparam logic [10:0] DSHOT_CMD_STOP     = 11'd0;
  localparam logic [10:0] DSHOT_THROTTLE_MIN = 11'd48;
  localparam logic [10:0] DSHOT_THROTTLE_MAX = 11'd2047;
  localparam logic [10:0] DSHOT_SPECIAL_MAX  = 11'd47;
  localparam logic [10:0] THROTTLE_IN_MAX    = 11'd2000;

  // Mixer throttle 1..2000 lands on DShot 48..2047; anything above clamps.
  function automatic logic [10:0] throttle_to_cmd(input logic [10:0] thr);
    if (thr == 11'd0)
      return DSHOT_CMD_STOP;
    else if (thr > THROTTLE_IN_MAX)
      return DSHOT_THROTTLE_MAX;
    else
      return thr + (DSHOT_THROTTLE_MIN - 11'd1);
  endfunction

  function automatic logic special_cmd_ok(input logic [5:0] cmd);
    return (cmd != 6'd0) && ({5'd0, cmd} <= DSHOT_SPECIAL_MAX);
  endfunction

endpackage

// File: rtl/dshot_frame_timer.sv
// Free-running wrap counter; tick marks the last cycle of every frame.
module dshot_frame_timer #(
  parameter int PERIOD = 8000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(PERIOD - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (tick) count_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/dshot_scheduler.sv
// Frame-rate scheduler and arming controller feeding four DShot transmitters:
// stop frames while disarmed, a zero-throttle arming hold, then live throttle.
module dshot_scheduler
  import dshot_pkg::*;
#(
  parameter int BASE_FREQ      = 16000000,
  parameter int DSHOT_FREQ     = 600000,
  parameter int UPDATE_FREQ    = 2000,
  parameter int ARM_FRAMES     = 200,
  parameter int SPECIAL_REPEAT = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arm,
  input  logic [43:0] throttle,
  input  logic        special_valid,
  input  logic [5:0]  special_cmd,
  input  logic [3:0]  special_mask,
  output logic        special_ready,
  output logic        special_done,
  output logic        special_err,
  output logic [43:0] command,
  output logic [3:0]  send,
  output logic        armed,
  output logic        frame_tick
);

  localparam int PERIOD = BASE_FREQ / UPDATE_FREQ;
  localparam int ACW    = $clog2(ARM_FRAMES + 1);
  localparam int RCW    = $clog2(SPECIAL_REPEAT + 1);

  // A full DShot frame is about 17 bit times; the update period must exceed it.
  if (PERIOD <= 17 * (BASE_FREQ / DSHOT_FREQ)) begin : g_period_check
    $error("dshot_scheduler: PERIOD too short for one DShot frame");
  end

  state_t           state_q;
  logic [ACW-1:0]   arm_cnt_q;
  logic [RCW-1:0]   rem_q;
  logic [5:0]       scmd_q;
  logic [3:0]       smask_q;
  logic [43:0]      command_q;
  logic [3:0]       send_q;
  logic             armed_q, ready_q, done_q, err_q;
  logic             tick, accept;
  logic [43:0]      thr_cmd;

  dshot_frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign accept = (state_q == ST_DISARMED) && ready_q && special_valid;

  always_comb begin
    thr_cmd = '0;
    for (int m = 0; m < 4; m++)
      thr_cmd[11*m +: 11] = throttle_to_cmd(throttle[11*m +: 11]);
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      scmd_q  <= special_cmd;
      smask_q <= special_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_DISARMED;
      arm_cnt_q <= '0;
      rem_q     <= '0;
      command_q <= '0;
      send_q    <= '0;
      armed_q   <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      send_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      case (state_q)
        ST_DISARMED: begin
          ready_q <= 1'b1;
          if (tick) begin
            command_q <= '0;
            send_q    <= 4'b1111;
          end
          if (accept) begin
            state_q <= ST_SPECIAL;
            ready_q <= 1'b0;
            rem_q   <= RCW'(SPECIAL_REPEAT);
            err_q   <= !special_cmd_ok(special_cmd);
          end else if (tick && arm) begin
            state_q   <= ST_ARMING;
            ready_q   <= 1'b0;
            arm_cnt_q <= ACW'(ARM_FRAMES);
          end
        end
        ST_ARMING: begin
          ready_q <= !arm;
          if (tick) begin
            command_q <= '0;
            send_q    <= 4'b1111;
            arm_cnt_q <= arm_cnt_q - 1'b1;
          end
          if (!arm)
            state_q <= ST_DISARMED;
          else if (tick && arm_cnt_q == ACW'(1))
            state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          ready_q <= !arm;
          if (!arm) begin
            state_q <= ST_DISARMED;
            armed_q <= 1'b0;
            if (tick) begin
              command_q <= '0;
              send_q    <= 4'b1111;
            end
          end else if (tick) begin
            command_q <= thr_cmd;
            send_q    <= 4'b1111;
            armed_q   <= 1'b1;
          end
        end
        ST_SPECIAL: begin
          if (!special_cmd_ok(scmd_q)) begin
            state_q <= ST_DISARMED;
            ready_q <= 1'b1;
          end else if (tick) begin
            // Unmasked motors keep whatever command they last held.
            for (int m = 0; m < 4; m++)
              if (smask_q[m]) command_q[11*m +: 11] <= {5'd0, scmd_q};
            send_q <= smask_q;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == RCW'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DISARMED;
              ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_DISARMED;
      endcase
    end
  end

  assign command       = command_q;
  assign send          = send_q;
  assign armed         = armed_q;
  assign special_ready = ready_q;
  assign special_done  = done_q;
  assign special_err   = err_q;
  assign frame_tick    = tick;

endmodule

// File: tb/tb_dshot_scheduler.sv
// Directed bench for dshot_scheduler at a 100-cycle frame, 3 arming frames
// and 2 special repeats.
module tb_dshot_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [43:0] throttle = '0;
  logic        special_valid = 1'b0;
  logic [5:0]  special_cmd = '0;
  logic [3:0]  special_mask = '0;
  logic        special_ready, special_done, special_err, armed, frame_tick;
  logic [43:0] command;
  logic [3:0]  send;

  int checks = 0;
  int errors = 0;

  dshot_scheduler #(
    .BASE_FREQ(1000000), .DSHOT_FREQ(250000), .UPDATE_FREQ(10000),
    .ARM_FRAMES(3), .SPECIAL_REPEAT(2)
  ) dut (
    .clock(clock), .reset(reset), .arm(arm), .throttle(throttle),
    .special_valid(special_valid), .special_cmd(special_cmd),
    .special_mask(special_mask), .special_ready(special_ready),
    .special_done(special_done), .special_err(special_err),
    .command(command), .send(send), .armed(armed), .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [43:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {11'(a3), 11'(a2), 11'(a1), 11'(a0)};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Returns in the cycle right after the next frame_tick, where send is visible.
  task automatic next_frame(output bit ok, output logic armed_at_tick);
    ok = 1'b0;
    armed_at_tick = 1'bx;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (frame_tick) begin
        ok = 1'b1;
        armed_at_tick = armed;
        break;
      end
    end
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) cyc();
    checks++;
    if ({command, send, armed, special_ready, special_done, special_err, frame_tick} !== '0) begin
      errors++;
      $display("FAIL reset_values: command=%h send=%b armed=%b rdy=%b done=%b err=%b tick=%b, required all 0",
               command, send, armed, special_ready, special_done, special_err, frame_tick);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (special_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: special_ready=%b, required 1", special_ready);
    end
    repeat (97) cyc();
    checks++;
    if (frame_tick !== 1'b0 || send !== 4'b0000) begin
      errors++;
      $display("FAIL pre_tick: tick=%b send=%b, required tick=0 send=0000", frame_tick, send);
    end
    cyc();
    checks++;
    if (frame_tick !== 1'b1 || send !== 4'b0000) begin
      errors++;
      $display("FAIL first_tick: tick=%b send=%b, required tick=1 send=0000", frame_tick, send);
    end
    cyc();
    checks++;
    if (send !== 4'b1111 || command !== 44'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL first_send: send=%b command=%h tick=%b, required send=1111 command=0 tick=0",
               send, command, frame_tick);
    end
    cyc();
    checks++;
    if (send !== 4'b0000) begin
      errors++;
      $display("FAIL send_width: send=%b, required 0000", send);
    end
  endtask

  task automatic test_arming();
    bit ok;
    logic at;
    throttle = pack(1000, 0, 2000, 2001);
    arm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_frame(ok, at);
      checks++;
      if (!ok || send !== 4'b1111 || command !== 44'd0 || armed !== 1'b0) begin
        errors++;
        $display("FAIL arm_zero_frame%0d: ok=%0d send=%b command=%h armed=%b, required send=1111 command=0 armed=0",
                 k, ok, send, command, armed);
      end
    end
    next_frame(ok, at);
    checks++;
    if (!ok || at !== 1'b0 || send !== 4'b1111 || command !== pack(1047, 0, 2047, 2047) || armed !== 1'b1) begin
      errors++;
      $display("FAIL arm_first_throttle: ok=%0d armed_at_tick=%b send=%b command=%h armed=%b, required 0/1111/%h/1",
               ok, at, send, command, armed, pack(1047, 0, 2047, 2047));
    end
  endtask

  task automatic test_throttle_hold();
    bit ok;
    bit extra;
    logic at;
    cyc();
    throttle = pack(2000, 1999, 1, 0);
    extra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (send !== 4'b0000) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL no_extra_send: send seen between ticks, required none");
    end
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b1111 || command !== pack(2047, 2046, 48, 0)) begin
      errors++;
      $display("FAIL throttle_map: send=%b command=%h, required 1111/%h", send, command, pack(2047, 2046, 48, 0));
    end
  endtask

  task automatic test_disarm_armed();
    bit ok;
    logic at;
    cyc();
    arm = 1'b0;
    cyc();
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL armed_fall: armed=%b, required 0", armed);
    end
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b1111 || command !== 44'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL disarm_armed_frame: send=%b command=%h armed=%b, required 1111/0/0", send, command, armed);
    end
  endtask

  task automatic test_disarm_arming();
    bit ok;
    logic at;
    arm = 1'b1;
    for (int k = 0; k < 3; k++) next_frame(ok, at);
    arm = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_frame(ok, at);
      checks++;
      if (!ok || send !== 4'b1111 || command !== 44'd0 || armed !== 1'b0) begin
        errors++;
        $display("FAIL disarm_arming_frame%0d: send=%b command=%h armed=%b, required 1111/0/0",
                 k, send, command, armed);
      end
    end
  endtask

  task automatic test_special();
    bit ok;
    logic at;
    cyc();
    checks++;
    if (special_ready !== 1'b1) begin
      errors++;
      $display("FAIL special_ready_idle: special_ready=%b, required 1", special_ready);
    end
    special_cmd = 6'd7;
    special_mask = 4'b0101;
    special_valid = 1'b1;
    cyc();
    special_valid = 1'b0;
    checks++;
    if (special_ready !== 1'b0 || special_err !== 1'b0) begin
      errors++;
      $display("FAIL special_accept: rdy=%b err=%b, required 0/0", special_ready, special_err);
    end
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b0101 || command !== pack(7, 0, 7, 0) || special_done !== 1'b0) begin
      errors++;
      $display("FAIL special_frame1: send=%b command=%h done=%b, required 0101/%h/0",
               send, command, special_done, pack(7, 0, 7, 0));
    end
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b0101 || command !== pack(7, 0, 7, 0) || special_done !== 1'b1) begin
      errors++;
      $display("FAIL special_frame2: send=%b command=%h done=%b, required 0101/%h/1",
               send, command, special_done, pack(7, 0, 7, 0));
    end
    cyc();
    checks++;
    if (special_done !== 1'b0 || send !== 4'b0000 || special_ready !== 1'b1) begin
      errors++;
      $display("FAIL special_after: done=%b send=%b rdy=%b, required 0/0000/1", special_done, send, special_ready);
    end
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b1111 || command !== 44'd0) begin
      errors++;
      $display("FAIL special_resume: send=%b command=%h, required 1111/0", send, command);
    end
  endtask

  task automatic test_special_err();
    bit ok;
    logic at;
    logic [5:0] bad [2];
    bad[0] = 6'd50;
    bad[1] = 6'd0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      special_cmd = bad[k];
      special_mask = 4'b1111;
      special_valid = 1'b1;
      cyc();
      special_valid = 1'b0;
      checks++;
      if (special_err !== 1'b1) begin
        errors++;
        $display("FAIL err_pulse_cmd%0d: err=%b, required 1", bad[k], special_err);
      end
      cyc();
      checks++;
      if (special_err !== 1'b0 || special_ready !== 1'b1) begin
        errors++;
        $display("FAIL err_end_cmd%0d: err=%b rdy=%b, required 0/1", bad[k], special_err, special_ready);
      end
      next_frame(ok, at);
      checks++;
      if (!ok || send !== 4'b1111 || command !== 44'd0 || special_done !== 1'b0) begin
        errors++;
        $display("FAIL err_no_send_cmd%0d: send=%b command=%h done=%b, required 1111/0/0",
                 bad[k], send, command, special_done);
      end
    end
    cyc();
    special_cmd = 6'd47;
    special_mask = 4'b1000;
    special_valid = 1'b1;
    cyc();
    special_valid = 1'b0;
    checks++;
    if (special_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cmd47: err=%b, required 0", special_err);
    end
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b1000 || command !== pack(0, 0, 0, 47)) begin
      errors++;
      $display("FAIL special_cmd47: send=%b command=%h, required 1000/%h", send, command, pack(0, 0, 0, 47));
    end
    next_frame(ok, at);
  endtask

  task automatic test_special_while_armed();
    bit ok;
    bit bad_seen;
    logic at;
    arm = 1'b1;
    for (int k = 0; k < 5; k++) next_frame(ok, at);
    checks++;
    if (armed !== 1'b1 || command !== pack(2047, 2046, 48, 0)) begin
      errors++;
      $display("FAIL rearm: armed=%b command=%h, required 1/%h", armed, command, pack(2047, 2046, 48, 0));
    end
    special_cmd = 6'd7;
    special_mask = 4'b1111;
    special_valid = 1'b1;
    bad_seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (special_ready !== 1'b0 || special_err !== 1'b0 || special_done !== 1'b0 ||
          (send !== 4'b0000 && (send !== 4'b1111 || command !== pack(2047, 2046, 48, 0))))
        bad_seen = 1'b1;
    end
    checks++;
    if (bad_seen || armed !== 1'b1) begin
      errors++;
      $display("FAIL special_blocked_armed: bad_seen=%0d armed=%b, required 0/1", bad_seen, armed);
    end
    special_valid = 1'b0;
    arm = 1'b0;
    next_frame(ok, at);
  endtask

  task automatic test_reset_mid_special();
    bit ok;
    bit done_seen;
    int first;
    logic [43:0] first_cmd;
    logic [3:0] first_send;
    logic at;
    cyc();
    special_cmd = 6'd9;
    special_mask = 4'b1111;
    special_valid = 1'b1;
    cyc();
    special_valid = 1'b0;
    next_frame(ok, at);
    checks++;
    if (!ok || send !== 4'b1111 || command !== pack(9, 9, 9, 9)) begin
      errors++;
      $display("FAIL mid_special_frame1: send=%b command=%h, required 1111/%h", send, command, pack(9, 9, 9, 9));
    end
    repeat (10) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    checks++;
    if ({command, send, armed, special_ready, special_done, special_err, frame_tick} !== '0) begin
      errors++;
      $display("FAIL mid_special_reset: command=%h send=%b armed=%b rdy=%b done=%b err=%b, required all 0",
               command, send, armed, special_ready, special_done, special_err);
    end
    reset = 1'b0;
    done_seen = 1'b0;
    first = -1;
    first_cmd = 'x;
    first_send = 'x;
    for (int i = 1; i <= 250; i++) begin
      cyc();
      if (special_done !== 1'b0) done_seen = 1'b1;
      if (send !== 4'b0000 && first < 0) begin
        first = i;
        first_cmd = command;
        first_send = send;
      end
    end
    checks++;
    if (done_seen || first != 100 || first_send !== 4'b1111 || first_cmd !== 44'd0) begin
      errors++;
      $display("FAIL restart_after_reset: done_seen=%0d first_send_cycle=%0d send=%b command=%h, required 0/100/1111/0",
               done_seen, first, first_send, first_cmd);
    end
  endtask

  initial begin
    test_reset();
    test_arming();
    test_throttle_hold();
    test_disarm_armed();
    test_disarm_arming();
    test_special();
    test_special_err();
    test_special_while_armed();
    test_reset_mid_special();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
